// File: rtl/s12_link_pkg.sv
// Shared constants and FSM state type for the S1->S2 serial link receiver.
// Frame layout, MSB first: address field, then payload field.
package s12_link_pkg;
   localparam int ADDR_W     = 3;
   localparam int DATA_W     = 18;
   localparam int FRAME_BITS = ADDR_W + DATA_W;
   localparam int NUM_FRAMES = 8;
   localparam int ADDR_MSB   = FRAME_BITS - 1;
   localparam int DATA_MSB   = DATA_W - 1;

   typedef enum logic [2:0] {IDLE, WRITE, READ, CHECK, DONE} state_t;
endpackage

// File: rtl/serial_frame_rx_if.sv
// RB2 register-bank pin bundle; the receiver is master, the bank is slave.
interface serial_frame_rx_if #(
   parameter int ADDR_W = s12_link_pkg::ADDR_W,
   parameter int DATA_W = s12_link_pkg::DATA_W
);
   logic              RB2_RW;
   logic [ADDR_W-1:0] RB2_A;
   logic [DATA_W-1:0] RB2_D;
   logic [DATA_W-1:0] RB2_Q;

   modport master (output RB2_RW, RB2_A, RB2_D, input RB2_Q);
   modport slave  (input RB2_RW, RB2_A, RB2_D, output RB2_Q);
endinterface

// File: rtl/serial_frame_shifter.sv
// Bit counter and shift register for sen/sd frames; flags short and long frames.
// frame_valid is combinational so the FSM can register WRITE on the last-bit edge.
module serial_frame_shifter #(
   parameter int ADDR_W = s12_link_pkg::ADDR_W,
   parameter int DATA_W = s12_link_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              sen,
   input  logic              sd,
   output logic              frame_valid,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data,
   output logic              frame_err
);
   localparam int FB = ADDR_W + DATA_W;
   localparam int BW = $clog2(FB + 1);

   logic [BW-1:0] bcnt;
   logic [FB-2:0] shreg;
   logic [FB-1:0] word;

   assign word        = {shreg, sd};
   assign frame_valid = enable && !sen && (bcnt == BW'(FB - 1));
   assign addr        = word[FB-1 -: ADDR_W];
   assign data        = word[DATA_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bcnt      <= '0;
         shreg     <= '0;
         frame_err <= 1'b0;
      end else if (!enable) begin
         bcnt <= '0;
      end else if (sen) begin
         // sen rising mid-frame discards the partial frame
         if (bcnt != '0 && bcnt != BW'(FB)) frame_err <= 1'b1;
         bcnt <= '0;
      end else if (bcnt != BW'(FB)) begin
         shreg <= word[FB-2:0];
         bcnt  <= bcnt + 1'b1;
      end else begin
         frame_err <= 1'b1;
      end
   end
endmodule

// File: rtl/serial_frame_rx.sv
// S2 frame receiver: writes each deserialised payload into RB2, reads it back
// to verify, and raises S2_done after NUM_FRAMES frames.
module serial_frame_rx #(
   parameter int ADDR_W     = s12_link_pkg::ADDR_W,
   parameter int DATA_W     = s12_link_pkg::DATA_W,
   parameter int NUM_FRAMES = s12_link_pkg::NUM_FRAMES
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sen,
   input  logic                sd,
   serial_frame_rx_if.master   rb2,
   output logic                S2_done,
   output logic                frame_err,
   output logic                verify_err
);
   import s12_link_pkg::*;

   localparam int FW = $clog2(NUM_FRAMES + 1);

   state_t            state;
   logic [FW-1:0]     fcnt;
   logic [ADDR_W-1:0] addr_lat;
   logic [DATA_W-1:0] data_lat;
   logic              f_valid;
   logic [ADDR_W-1:0] f_addr;
   logic [DATA_W-1:0] f_data;
   logic              rw_q;
   logic [ADDR_W-1:0] a_q;
   logic [DATA_W-1:0] d_q;

   serial_frame_shifter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_shift (
      .clk         (clk),
      .rst         (rst),
      .enable      (state != DONE),
      .sen         (sen),
      .sd          (sd),
      .frame_valid (f_valid),
      .addr        (f_addr),
      .data        (f_data),
      .frame_err   (frame_err)
   );

   assign rb2.RB2_RW = rw_q;
   assign rb2.RB2_A  = a_q;
   assign rb2.RB2_D  = d_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         fcnt       <= '0;
         addr_lat   <= '0;
         data_lat   <= '0;
         rw_q       <= 1'b1;
         a_q        <= '0;
         d_q        <= '0;
         S2_done    <= 1'b0;
         verify_err <= 1'b0;
      end else begin
         rw_q <= 1'b1;
         a_q  <= '0;
         d_q  <= '0;
         case (state)
            IDLE: if (f_valid) begin
               addr_lat <= f_addr;
               data_lat <= f_data;
               rw_q     <= 1'b0;
               a_q      <= f_addr;
               d_q      <= f_data;
               state    <= WRITE;
            end
            WRITE: begin
               a_q   <= addr_lat;
               state <= READ;
            end
            READ: state <= CHECK;
            CHECK: begin
               // RB2_Q holds the word sampled on the READ cycle
               if (rb2.RB2_Q != data_lat) verify_err <= 1'b1;
               fcnt <= fcnt + 1'b1;
               if (fcnt == FW'(NUM_FRAMES - 1)) begin
                  state   <= DONE;
                  S2_done <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            DONE:    S2_done <= 1'b1;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Downstream receiver of the S1→S2 serial link. Deserialises 21-bit frames (3-bit address + 18-bit payload) from `sen`/`sd`, writes each payload into the 8×18 register bank RB2, reads the word back to verify it, and raises `S2_done` after a fixed number of frames. It replaces the bare S2 write path with framing and read-back checking, and connects directly to the RB2 port pins.

## Interface
- `ADDR_W`, default 3: frame address field width, which is also the RB2 address width.
- `DATA_W`, default 18: frame payload width, which is also the RB2 word width.
- `NUM_FRAMES`, default 8: number of accepted frames before done.
- Frame length is FRAME_BITS = ADDR_W + DATA_W, which is 21 with the defaults.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-high.
- `sen`  in  1  frame enable, active low. High means idle; low means a bit is present on `sd`.
- `sd`  in  1  serial data, MSB first.
- `RB2_RW`  out  1  RB2 WENn: 0 = write, 1 = read/idle.
- `RB2_A`  out  ADDR_W  RB2 address.
- `RB2_D`  out  DATA_W  RB2 write data.
- `RB2_Q`  in  DATA_W  RB2 read data. It is synchronous: valid after the edge that samples A with WENn=1.
- `S2_done`  out  1  all NUM_FRAMES frames written and verified. Sticky.
- `frame_err`  out  1  sticky framing error.
- `verify_err`  out  1  sticky read-back mismatch.

## Operation
- **Bit counter** `bcnt` (0..FRAME_BITS), reset 0.
  - While `sen`=1, `bcnt` is held at 0.
  - On each edge with `sen`=0 and `bcnt` < FRAME_BITS: `shreg` ← {`shreg`[FRAME_BITS-2:0], `sd`}, and `bcnt`++.
- **Frame completion.** When the 21st bit is shifted in, a frame is complete. `addr_lat` = bits[20:18] and `data_lat` = bits[17:0] are latched into holding registers, separate from `shreg`.
- **FSM**, reset state IDLE:
  - IDLE: on frame complete → WRITE.
  - WRITE (1 cycle): `RB2_RW`=0, `RB2_A`=`addr_lat`, `RB2_D`=`data_lat`. Next state READ.
  - READ (1 cycle): `RB2_RW`=1, `RB2_A`=`addr_lat`. Next state CHECK.
  - CHECK (1 cycle):
    - compare `RB2_Q` to `data_lat`; on mismatch set `verify_err`;
    - increment `fcnt`;
    - if `fcnt` reaches NUM_FRAMES → DONE, else → IDLE.
  - DONE: terminal. `S2_done`=1, `RB2_RW`=1. Further frames are ignored: no shifting, no writes. Leaves DONE only on `rst`.
- **Frames are accepted regardless of address.** Duplicate addresses overwrite and still count. `fcnt` counts frames, not distinct addresses.
- **Framing errors** set `frame_err`:
  - `sen` rises with 0 < `bcnt` < FRAME_BITS: the partial frame is discarded, `fcnt` is unchanged, and no RB2 access occurs.
  - `sen` still low when `bcnt` = FRAME_BITS, i.e. a 22nd bit: the extra bits are ignored until `sen` returns high. The completed 21-bit frame is still processed.
- **Default outputs** when not in WRITE/READ: `RB2_RW`=1, `RB2_A`=0, `RB2_D`=0. All outputs are registered.
- **Reset values:** `RB2_RW`=1, `RB2_A`=0, `RB2_D`=0, `S2_done`=0, `frame_err`=0, `verify_err`=0, `fcnt`=0, `bcnt`=0.
- **Reset mid-frame or mid-write** aborts immediately. RB2 contents are not restored. The counters restart from zero.

## Timing
- Let edge *t* be the edge that samples the last bit of a frame.
- WRITE outputs are driven after *t*. RB2 writes at edge *t*+1.
- READ outputs are driven after *t*+1. RB2 samples A at *t*+2. `RB2_Q` is compared at edge *t*+3.
- `S2_done` rises after edge *t*+3 of the NUM_FRAMES-th frame, so latency from the last bit to done is 3 cycles.
- The minimum `sen`-high gap between frames is 1 cycle. The next frame's last bit is ≥21 cycles after *t*, so it cannot collide with WRITE/READ/CHECK. Shifting may overlap the FSM.
- `S2_done`, `frame_err` and `verify_err` stay asserted until `rst`.

## Structure
- Shared package `s12_link_pkg` holds:
  - ADDR_W, DATA_W, FRAME_BITS, NUM_FRAMES;
  - the FSM state enum {IDLE, WRITE, READ, CHECK, DONE};
  - frame field index constants ADDR_MSB=20 and DATA_MSB=17.
- Sub-module `serial_frame_shifter` contains `bcnt`, `shreg`, the framing-error detection, and a one-cycle `frame_valid` pulse with `addr`/`data`. `serial_frame_rx` contains the FSM, the latches, `fcnt` and the RB2 drive.

## Test plan
- **Eight good frames**, addresses 0..7, payloads 18'h3FFFF, 18'h00001, …; 1-cycle gaps → RB2[k] equals the payload sent; `S2_done`=1 three cycles after the last bit; both error flags stay 0.
- **Write/read timing:** frame addr 3'b101, data 18'h2A5A5 → `RB2_RW`=0 with A=5, D=2A5A5 exactly one cycle after the last bit, then `RB2_RW`=1 with A=5 for one cycle.
- **Short frame:** `sen` rises after 10 bits → `frame_err`=1, no RB2 access, `fcnt` unchanged; the next good frame is written normally.
- **Long frame:** `sen` held low for 25 bits → the first 21 bits are written, `frame_err`=1, `fcnt`+1.
- **Read-back fault:** the RB2 model forces Q=18'h00000 for addr 2 while 18'h12345 was written → `verify_err`=1; done still asserts after frame 8.
- **Reset and post-done behaviour:**
  - `rst` pulse during bit 12 of frame 4 → all outputs return to reset values; 8 fresh frames complete done.
  - An extra frame after done → no RB2 write.
